seg7_scan_buffer: RTL

- Display back-end that consumes the byte stream produced by the UART receive controller.
- Stores up to 8 received bytes in a circular digit buffer.
- Time-multiplexes the buffer onto the 8-digit common-anode 7-segment display, one digit at a time, with a blanking gap between digits to suppress ghosting.
- Replaces the free-running scan counter and fixed register bank currently inlined in the controller, and adds a proper write handshake.

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_hex_decode.sv | 19 +
 rtl/seg7_scan_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//
// Shared definitions for the 7-segment display back-end:
//   NUM_DIGITS     number of digits in the buffer and on the display
//   SEG_OFF        active-low segment pattern with every segment dark
//   EN_OFF         active-low digit-enable pattern with every digit off
//   HEX_SEG_TABLE  16-entry nibble -> segment table (active-low, bit6=a..bit0=g)
//   scan_state_t   scan FSM state encoding {SHOW, BLANK}
//   hex_to_seg()   table lookup helper
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] EN_OFF  = 8'hFF;

   // Packed so that HEX_SEG_TABLE[n] is the pattern for nibble n; the first
   // element of the concatenation is therefore the entry for 4'hF.
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } scan_state_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return HEX_SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
//
// Purely combinational hex-digit to 7-segment decoder (active-low segments).
//
// Ports:
//   nibble  in  4  value to display (0..F)
//   seg     out 7  segment pattern, active-low, bit6=a .. bit0=g
// -----------------------------------------------------------------------------
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_buffer.sv
// -----------------------------------------------------------------------------
// seg7_scan_buffer
//
// Display back-end for the UART receive path. Received bytes are written into
// an 8-entry circular digit buffer (oldest entry overwritten on wrap) and the
// buffer is time-multiplexed onto an 8-digit common-anode 7-segment display,
// one digit at a time, with an optional all-off gap between digits to
// suppress ghosting. Only the low nibble of each byte is displayed.
//
// Parameters:
//   REFRESH_DIV   clock cycles each digit is driven (>= 1)
//   BLANK_CYCLES  all-off cycles between consecutive digits (0 = no gap)
//
// Ports:
//   i_clk       in  1  system clock
//   i_reset     in  1  asynchronous active-high reset
//   i_wr_valid  in  1  byte-write request
//   i_wr_data   in  8  received byte
//   o_wr_ready  out 1  buffer accepts a write this cycle
//   i_clear     in  1  single-cycle clear of buffer, write pointer and count
//   o_count     out 4  number of valid digits, saturating at 8
//   o_a_to_g    out 7  segments, active-low, bit6=a .. bit0=g
//   o_dp        out 1  decimal point, active-low
//   o_en        out 8  digit enables, active-low, bit7 = digit 0 (leftmost)
//
// Build option:
//   SEG7_CURSOR_EN  when defined, the decimal point lights on the digit at the
//                   write pointer (next write position) while it is shown;
//                   when undefined, o_dp is constant 1.
// -----------------------------------------------------------------------------
module seg7_scan_buffer
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 125000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_wr_valid,
   input  logic [7:0] i_wr_data,
   output logic       o_wr_ready,
   input  logic       i_clear,
   output logic [3:0] o_count,
   output logic [6:0] o_a_to_g,
   output logic       o_dp,
   output logic [7:0] o_en
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PTR_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [3:0]       COUNT_MAX  = 4'(NUM_DIGITS);

   // ------------------------------------------------------------------------
   // Write side: handshake, pointer, occupancy count
   // ------------------------------------------------------------------------
   logic             wr_ready_reg;
   logic [PTR_W-1:0] wptr_reg;
   logic [3:0]       count_reg;
   logic [7:0]       digit_buf_reg [NUM_DIGITS];
   logic             wr_fire;

   // A clear in the same cycle as a write wins; the byte is dropped.
   assign wr_fire = i_wr_valid && wr_ready_reg && !i_clear;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ready_reg <= 1'b0;
         wptr_reg     <= '0;
         count_reg    <= '0;
      end else begin
         // Ready drops for exactly the cycle after a clear pulse.
         wr_ready_reg <= !i_clear;
         if (i_clear) begin
            wptr_reg  <= '0;
            count_reg <= '0;
         end else if (wr_fire) begin
            wptr_reg <= wptr_reg + 1'b1;   // natural wrap 7 -> 0
            if (count_reg != COUNT_MAX) begin
               count_reg <= count_reg + 4'd1;
            end
         end
      end
   end

   // Buffer kept in flops: every entry is cleared in one cycle and the scan
   // reads an arbitrary entry combinationally, which a RAM cannot provide.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               digit_buf_reg[gi] <= 8'h00;
            end else if (i_clear) begin
               digit_buf_reg[gi] <= 8'h00;
            end else if (wr_fire && (wptr_reg == PTR_W'(gi))) begin
               digit_buf_reg[gi] <= i_wr_data;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Scan FSM
   // ------------------------------------------------------------------------
   scan_state_t      state_reg, state_next;
   logic [PTR_W-1:0] digit_reg, digit_next;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   logic [7:0]       en_reg,    en_next;
   logic [6:0]       seg_reg,   seg_next;

   logic [7:0]       shown_byte;
   logic [6:0]       shown_seg;
   logic             unused_hi;

   assign shown_byte = digit_buf_reg[digit_reg];
   // Upper nibble of each byte is stored but never displayed.
   assign unused_hi  = ^shown_byte[7:4];

   seg7_hex_decode u_hex_decode (
      .nibble (shown_byte[3:0]),
      .seg    (shown_seg)
   );

`ifdef SEG7_CURSOR_EN
   logic dp_reg, dp_next;
`endif

   // Outputs are computed from the current state/digit and registered, so the
   // display lags the FSM by one edge. This makes the first edge after reset
   // drive digit 0 and makes a write to the shown digit visible one edge after
   // the write edge.
   always_comb begin
      state_next = state_reg;
      digit_next = digit_reg;
      cnt_next   = cnt_reg + 1'b1;
      en_next    = EN_OFF;
      seg_next   = SEG_OFF;
`ifdef SEG7_CURSOR_EN
      dp_next    = 1'b1;
`endif
      case (state_reg)
         SHOW: begin
            en_next  = ~(8'h80 >> digit_reg);
            seg_next = shown_seg;
`ifdef SEG7_CURSOR_EN
            dp_next  = (digit_reg != wptr_reg);
`endif
            if (cnt_reg == SHOW_LAST) begin
               cnt_next = '0;
               if (BLANK_CYCLES > 0) begin
                  state_next = BLANK;
               end else begin
                  digit_next = digit_reg + 1'b1;
               end
            end
         end
         BLANK: begin
            if (cnt_reg == BLANK_LAST) begin
               cnt_next   = '0;
               state_next = SHOW;
               digit_next = digit_reg + 1'b1;
            end
         end
         default: begin
            state_next = SHOW;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= SHOW;
         digit_reg <= '0;
         cnt_reg   <= '0;
         en_reg    <= EN_OFF;
         seg_reg   <= SEG_OFF;
      end else begin
         state_reg <= state_next;
         digit_reg <= digit_next;
         cnt_reg   <= cnt_next;
         en_reg    <= en_next;
         seg_reg   <= seg_next;
      end
   end

`ifdef SEG7_CURSOR_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         dp_reg <= 1'b1;
      end else begin
         dp_reg <= dp_next;
      end
   end

   assign o_dp = dp_reg;
`else
   assign o_dp = 1'b1;
`endif

   assign o_wr_ready = wr_ready_reg;
   assign o_count    = count_reg;
   assign o_en       = en_reg;
   assign o_a_to_g   = seg_reg;

endmodule
